// File: rtl/multimode_counter.sv
// Multimode modulo counter: binary up, binary down, up/down ping-pong and Gray-coded up,
// with clamped synchronous load, an asynchronous active-low reset and a terminal-count flag.
module multimode_counter #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_dir,
  output logic             o_tc
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_GRAY = 2'b11
  } mode_e;

  // Largest legal count. It fits in WIDTH bits even when MODULO == 2**WIDTH,
  // so every range test below stays inside the register width.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);

  mode_e            mode;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  logic             at_max, at_zero, at_terminal;

  assign mode    = mode_e'(i_mode);
  assign at_max  = (cnt_q == CNT_MAX);
  assign at_zero = (cnt_q == '0);
  assign cnt_inc = at_max  ? '0      : cnt_q + 1'b1;
  assign cnt_dec = at_zero ? CNT_MAX : cnt_q - 1'b1;

  // NOTE: every variable gets a default before the branches, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (i_load) begin
      cnt_d = (i_load_val > CNT_MAX) ? CNT_MAX : i_load_val;
    end else if (i_en) begin
      case (mode)
        MODE_UP, MODE_GRAY: begin
          cnt_d = cnt_inc;
          dir_d = 1'b0;
        end
        MODE_DOWN: begin
          cnt_d = cnt_dec;
          dir_d = 1'b1;
        end
        MODE_PING: begin
          // The turnaround edge reverses direction and steps away from the end in one go.
          if (!dir_q) begin
            cnt_d = at_max ? cnt_dec : cnt_inc;
            dir_d = at_max;
          end else begin
            cnt_d = at_zero ? cnt_inc : cnt_dec;
            dir_d = !at_zero;
          end
        end
        default: begin
          cnt_d = cnt_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      dir_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    at_terminal = 1'b0;
    case (mode)
      MODE_UP, MODE_GRAY: at_terminal = at_max;
      MODE_DOWN:          at_terminal = at_zero;
      MODE_PING:          at_terminal = dir_q ? at_zero : at_max;
      default:            at_terminal = 1'b0;
    endcase
  end

  assign o_cnt = (mode == MODE_GRAY) ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;
  assign o_dir = dir_q;
  assign o_tc  = i_en && !i_load && at_terminal;

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: a MODULO=10 and a MODULO=16 instance driven in parallel,
// checked with a constant vector table, directed corner sequences and a random run vs a model.
module tb_multimode_counter;

  localparam int W   = 4;
  localparam int M_A = 10;
  localparam int M_B = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] cnt_a, cnt_b;
  logic         dir_a, dir_b, tc_a, tc_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multimode_counter #(.WIDTH(W), .MODULO(M_A)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_load(load),
    .i_load_val(load_val), .o_cnt(cnt_a), .o_dir(dir_a), .o_tc(tc_a)
  );

  multimode_counter #(.WIDTH(W), .MODULO(M_B)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_load(load),
    .i_load_val(load_val), .o_cnt(cnt_b), .o_dir(dir_b), .o_tc(tc_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { int c; int d; } st_t;

  function automatic st_t ref_next(input int m, input int mo, input int e, input int ld,
                                   input int lv, input st_t s);
    st_t n = s;
    if (ld != 0) begin
      n.c = (lv > m - 1) ? m - 1 : lv;
    end else if (e != 0) begin
      case (mo)
        0, 3: begin n.c = (s.c + 1) % m;     n.d = 0; end
        1:    begin n.c = (s.c + m - 1) % m; n.d = 1; end
        default: begin
          if (s.d == 0 && s.c == m - 1) n.d = 1;
          else if (s.d == 1 && s.c == 0) n.d = 0;
          n.c = (n.d != 0) ? s.c - 1 : s.c + 1;
        end
      endcase
    end
    return n;
  endfunction

  function automatic int ref_out(input int c, input int mo);
    return (mo == 3) ? (c ^ (c >> 1)) : c;
  endfunction

  function automatic int ref_tc(input int m, input st_t s, input int mo, input int e, input int ld);
    int term;
    if (e == 0 || ld != 0) return 0;
    term = (mo == 1 || (mo == 2 && s.d == 1)) ? 0 : m - 1;
    return (s.c == term) ? 1 : 0;
  endfunction

  st_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{c: 0, d: 0};
      mb <= '{c: 0, d: 0};
    end else begin
      ma <= ref_next(M_A, int'(mode), int'(en), int'(load), int'(load_val), ma);
      mb <= ref_next(M_B, int'(mode), int'(en), int'(load), int'(load_val), mb);
    end
  end

  task automatic check_model(input string tag);
    check({tag, "_cnt_a"}, 32'(cnt_a), ref_out(ma.c, int'(mode)));
    check({tag, "_dir_a"}, 32'(dir_a), ma.d);
    check({tag, "_tc_a"},  32'(tc_a),  ref_tc(M_A, ma, int'(mode), int'(en), int'(load)));
    check({tag, "_cnt_b"}, 32'(cnt_b), ref_out(mb.c, int'(mode)));
    check({tag, "_dir_b"}, 32'(dir_b), mb.d);
    check({tag, "_tc_b"},  32'(tc_b),  ref_tc(M_B, mb, int'(mode), int'(en), int'(load)));
  endtask

  // ---------------- vector table (MODULO=10 instance) ----------------
  typedef struct {
    bit         rst;
    bit         en;
    logic [1:0] mode;
    bit         load;
    logic [3:0] lv;
    int         cnt;
    bit         dir;
    bit         tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit r, input bit e, input logic [1:0] mo, input bit l,
                              input logic [3:0] lv, input int c, input bit d, input bit t);
    vec_t v;
    v.rst = r; v.en = e; v.mode = mo; v.load = l; v.lv = lv;
    v.cnt = c; v.dir = d; v.tc = t;
    vecs.push_back(v);
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input bit e, input logic [1:0] mo, input bit l, input logic [3:0] lv);
    en = e; mode = mo; load = l; load_val = lv;
  endtask

  initial begin
    logic [W-1:0] prev;
    int           gray;

    // Up: 1..9,0,1,2 with tc only at 9.
    add(1, 1, 2'b00, 0, 4'd0, 1, 0, 0);
    for (int k = 2; k <= 9; k++) add(0, 1, 2'b00, 0, 4'd0, k, 0, k == 9);
    add(0, 1, 2'b00, 0, 4'd0, 0, 0, 0);
    add(0, 1, 2'b00, 0, 4'd0, 1, 0, 0);
    add(0, 1, 2'b00, 0, 4'd0, 2, 0, 0);
    // Down: 9,8..0,9 with dir=1 and tc only at 0.
    add(1, 1, 2'b01, 0, 4'd0, 9, 1, 0);
    for (int k = 8; k >= 0; k--) add(0, 1, 2'b01, 0, 4'd0, k, 1, k == 0);
    add(0, 1, 2'b01, 0, 4'd0, 9, 1, 0);
    // Ping-pong: 1..9, 8..0, 1, 2.
    add(1, 1, 2'b10, 0, 4'd0, 1, 0, 0);
    for (int k = 2; k <= 9; k++) add(0, 1, 2'b10, 0, 4'd0, k, 0, k == 9);
    for (int k = 8; k >= 0; k--) add(0, 1, 2'b10, 0, 4'd0, k, 1, k == 0);
    add(0, 1, 2'b10, 0, 4'd0, 1, 0, 0);
    add(0, 1, 2'b10, 0, 4'd0, 2, 0, 0);
    // Loads: clamp 13 -> 9, then load 5 while counting down in ping-pong.
    add(1, 1, 2'b00, 1, 4'd13, 9, 0, 0);
    add(0, 1, 2'b10, 0, 4'd0,  8, 1, 0);
    add(0, 1, 2'b10, 1, 4'd5,  5, 1, 0);
    add(0, 1, 2'b10, 0, 4'd0,  4, 1, 0);

    // Reset state, asserted from time zero with no clock edge needed.
    #3;
    check("rst_cnt_a", 32'(cnt_a), 0);
    check("rst_dir_a", 32'(dir_a), 0);
    check("rst_tc_a",  32'(tc_a),  0);
    check("rst_cnt_b", 32'(cnt_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst) pulse_reset();
      set_in(vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].lv);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_cnt", i), 32'(cnt_a), vecs[i].cnt);
      check($sformatf("tbl%0d_dir", i), 32'(dir_a), 32'(vecs[i].dir));
      check($sformatf("tbl%0d_tc", i),  32'(tc_a),  32'(vecs[i].tc));
    end

    // Gray mode on the full-range instance: 16 steps, one bit changing per step.
    @(negedge clk);
    pulse_reset();
    set_in(1, 2'b11, 0, 4'd0);
    #1;
    check("gray_start", 32'(cnt_b), 0);
    prev = cnt_b;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      gray = (i % 16) ^ ((i % 16) >> 1);
      check($sformatf("gray%0d", i), 32'(cnt_b), gray);
      check($sformatf("gray%0d_1bit", i), $countones(cnt_b ^ prev), 1);
      prev = cnt_b;
    end

    // Mode change is seen on o_cnt with no clock edge and leaves the count alone.
    @(negedge clk);
    pulse_reset();
    set_in(1, 2'b00, 0, 4'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    set_in(0, 2'b11, 0, 4'd0);
    #1;
    check("modechg_gray", 32'(cnt_a), 7);
    mode = 2'b00;
    #1;
    check("modechg_bin", 32'(cnt_a), 5);

    // Async reset between edges at a ping-pong turnaround, with a load pending.
    @(negedge clk);
    pulse_reset();
    set_in(1, 2'b10, 0, 4'd0);
    repeat (10) @(posedge clk);
    #1;
    check("pp_pre_cnt", 32'(cnt_a), 8);
    check("pp_pre_dir", 32'(dir_a), 1);
    #1;
    rst_n = 1'b0;
    load = 1'b1;
    load_val = 4'd7;
    #1;
    check("arst_cnt", 32'(cnt_a), 0);
    check("arst_dir", 32'(dir_a), 0);
    check("arst_tc",  32'(tc_a),  0);
    @(posedge clk);
    #1;
    check("arst_hold_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 2'b10, 0, 4'd0);
    @(posedge clk);
    #1;
    check("post_rst_cnt", 32'(cnt_a), 1);
    check("post_rst_dir", 32'(dir_a), 0);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_cnt", i), 32'(cnt_a), 1);
      check($sformatf("hold%0d_tc", i),  32'(tc_a),  0);
    end

    // Random run against the model, both instances, with occasional async resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rnd_arst_cnt", 32'(cnt_a), ref_out(0, int'(mode)));
        rst_n = 1'b1;
      end
      #1;
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
